// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the
// 4-digit scan sequencer.
package scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 2;

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter timing SHOW and
// GAP phases; tc marks the final cycle.
module scan_slot_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         tc_next
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc      = (cnt == '0);
  assign tc_next = load ? (load_val == '0)
                        : (cnt <= W'(1));

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed digit scan with frame-
// latched data and a blanking gap per slot.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  blank_mask,
  output logic        sel_a,
  output logic        sel_b,
  output logic [3:0]  nibble,
  output logic        digit_valid,
  output logic        frame_done
);

  localparam int MAXC =
    (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SHOW_LD = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LD =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
  localparam state_t END_ST = (BLANK_CYCLES > 0) ? GAP : SHOW;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [15:0]      lat, lat_n;
  logic             ld;
  logic [CW-1:0]    ld_val;
  logic             tc, tc_next;
  logic             fd_n;
  logic             vld_n;

  scan_slot_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .load_val(ld_val),
    .tc      (tc),
    .tc_next (tc_next)
  );

  // Next state, digit index, frame latch and timer reloads.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    lat_n   = lat;
    ld      = 1'b0;
    ld_val  = SHOW_LD;
    if (state != IDLE && !en) begin
      state_n = IDLE;
      idx_n   = '0;
      ld      = 1'b1;
      ld_val  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          ld = 1'b1;
          if (en) begin
            state_n = SHOW;
            idx_n   = '0;
            lat_n   = value;
          end else begin
            ld_val = '0;
          end
        end
        SHOW: begin
          if (tc) begin
            ld = 1'b1;
            if (BLANK_CYCLES > 0) begin
              state_n = GAP;
              ld_val  = GAP_LD;
            end else begin
              idx_n = idx + IDX_W'(1);
              if (idx == LAST) lat_n = value;
            end
          end
        end
        GAP: begin
          if (tc) begin
            state_n = SHOW;
            ld      = 1'b1;
            idx_n   = idx + IDX_W'(1);
            if (idx == LAST) lat_n = value;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
        end
      endcase
    end
    fd_n  = (state_n == END_ST) && (idx_n == LAST)
         && tc_next;
    vld_n = (state_n == SHOW) && !blank_mask[idx_n];
  end

  // Sequencer state, digit index and frame-latched value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      lat   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      lat   <= lat_n;
    end
  end

  // Outputs registered from next-state so they all move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_a       <= 1'b0;
      sel_b       <= 1'b0;
      nibble      <= '0;
      digit_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      sel_a       <= (state_n != IDLE) && idx_n[1];
      sel_b       <= (state_n != IDLE) && idx_n[0];
      nibble      <= vld_n ? lat_n[{idx_n, 2'b00} +: 4] : 4'h0;
      digit_valid <= vld_n;
      frame_done  <= fd_n;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with a
// timeline model for two parameter sets.
module tb_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  blank_mask;

  logic       a0, b0, v0, f0;
  logic [3:0] n0;
  logic       a1, b1, v1, f1;
  logic [3:0] n1;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  scan_sequencer #(
    .PRESCALE    (4),
    .BLANK_CYCLES(2)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .blank_mask (blank_mask),
    .sel_a      (a0),
    .sel_b      (b0),
    .nibble     (n0),
    .digit_valid(v0),
    .frame_done (f0)
  );

  scan_sequencer #(
    .PRESCALE    (1),
    .BLANK_CYCLES(0)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .blank_mask (blank_mask),
    .sel_a      (a1),
    .sel_b      (b1),
    .nibble     (n1),
    .digit_valid(v1),
    .frame_done (f1)
  );

  wire [7:0] o0 = {a0, b0, v0, n0, f0};
  wire [7:0] o1 = {a1, b1, v1, n1, f1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per DUT, whether running and cycle offset in frame.
  int          act [2];
  int          t   [2];
  logic [15:0] lat [2];
  logic [3:0]  msk [2];

  function automatic int slot_len(int d);
    return (d == 0) ? 6 : 1;
  endfunction

  function automatic int show_len(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 0;
      t[d]   = 0;
      lat[d] = '0;
      msk[d] = '0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        msk[d] = blank_mask;
        if (rst) begin
          act[d] = 0;
        end else if (act[d] == 0) begin
          if (en) begin
            act[d] = 1;
            t[d]   = 0;
            lat[d] = value;
          end
        end else if (!en) begin
          act[d] = 0;
        end else if (t[d] == 4 * slot_len(d) - 1) begin
          t[d]   = 0;
          lat[d] = value;
        end else begin
          t[d] = t[d] + 1;
        end
      end
    end
  end

  function automatic logic [7:0] expect_out(int d);
    int         dg;
    int         pos;
    logic       vv;
    logic [3:0] nb;
    logic       fd;
    if (act[d] == 0) return 8'h00;
    dg = t[d] / slot_len(d);
    pos = t[d] % slot_len(d);
    vv = (pos < show_len(d)) && !msk[d][dg];
    nb = vv ? lat[d][dg*4 +: 4] : 4'h0;
    fd = (t[d] == 4 * slot_len(d) - 1);
    return {dg[1:0], vv, nb, fd};
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h {sel,valid,nib,fd}",
               nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pk(input logic [1:0] s,
                                    input logic v,
                                    input logic [3:0] n,
                                    input logic f);
    return {s, v, n, f};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every-cycle comparison against the model.
  initial begin
    wait (chk_on);
    forever begin
      @(negedge clk);
      chk("dut0 cycle", o0, expect_out(0));
      chk("dut1 cycle", o1, expect_out(1));
    end
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    value      = 16'hA3C5;
    blank_mask = 4'b0000;
    tick(3);
    chk_on = 1;
    chk("reset d0", o0, 8'h00);
    chk("reset d1", o1, 8'h00);
    rst = 1'b0;
    tick(1);
    chk("idle after reset", o0, 8'h00);

    // basic scan, t counts cycles of dut0's frame
    en = 1'b1;
    tick(1);
    chk("t0 d0", o0, pk(2'd0, 1'b1, 4'h5, 1'b0));
    chk("t0 d1", o1, pk(2'd0, 1'b1, 4'h5, 1'b0));
    tick(1);
    chk("t1 d1", o1, pk(2'd1, 1'b1, 4'hC, 1'b0));
    tick(2);
    chk("t3 d1 frame", o1, pk(2'd3, 1'b1, 4'hA, 1'b1));
    tick(1);
    chk("t4 d0 gap", o0, pk(2'd0, 1'b0, 4'h0, 1'b0));
    tick(2);
    chk("t6 d0", o0, pk(2'd1, 1'b1, 4'hC, 1'b0));
    tick(6);
    chk("t12 d0", o0, pk(2'd2, 1'b1, 4'h3, 1'b0));
    tick(6);
    chk("t18 d0", o0, pk(2'd3, 1'b1, 4'hA, 1'b0));
    tick(5);
    chk("t23 d0 frame", o0, pk(2'd3, 1'b0, 4'h0, 1'b1));

    // frame latch: change value during digit 1
    tick(9);
    value = 16'h1234;
    tick(4);
    chk("latch old d2", o0, pk(2'd2, 1'b1, 4'h3, 1'b0));
    tick(6);
    chk("latch old d3", o0, pk(2'd3, 1'b1, 4'hA, 1'b0));
    tick(6);
    chk("latch new d0", o0, pk(2'd0, 1'b1, 4'h4, 1'b0));
    tick(6);
    chk("latch new d1", o0, pk(2'd1, 1'b1, 4'h3, 1'b0));

    // masking digit 2
    blank_mask = 4'b0100;
    tick(6);
    chk("mask d2 first", o0, pk(2'd2, 1'b0, 4'h0, 1'b0));
    tick(5);
    chk("mask d2 last", o0, pk(2'd2, 1'b0, 4'h0, 1'b0));
    tick(1);
    chk("mask d3", o0, pk(2'd3, 1'b1, 4'h1, 1'b0));
    blank_mask = 4'b0000;

    // abort during digit 2
    tick(18);
    chk("pre-abort d2", o0, pk(2'd2, 1'b1, 4'h2, 1'b0));
    en = 1'b0;
    tick(1);
    chk("abort d0", o0, 8'h00);
    chk("abort d1", o1, 8'h00);
    en    = 1'b1;
    value = 16'hBEEF;
    tick(1);
    chk("restart d0", o0, pk(2'd0, 1'b1, 4'hF, 1'b0));

    // reset during SHOW
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("mid rst d0", o0, 8'h00);
    rst   = 1'b0;
    value = 16'hA3C5;
    tick(1);
    chk("rst restart t0", o0, pk(2'd0, 1'b1, 4'h5, 1'b0));
    tick(23);
    chk("rst restart t23", o0, pk(2'd3, 1'b0, 4'h0, 1'b1));
    tick(1);
    chk("rst restart t24", o0, pk(2'd0, 1'b1, 4'h5, 1'b0));
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
